dmem_responder: RTL and testbench

- Data-memory responder: the target side of the load/store request that decode generates (vld, mtype, len) and the later stages carry forward with an address and store data.
- Holds a word-organised SRAM model.
- Accepts one request at a time on a valid/ready handshake, performs the byte/half/word access after a programmable latency, and returns a response on a second valid/ready handshake.
- Sits between the M stage and the data memory array. Used in core simulation and as the FPGA data RAM.

---
 rtl/dmem_if.sv | 30 +++
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 tb/tb_dmem_responder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Request/response bus between the M stage and the data memory responder.
//
// Handshake rules: a transfer happens on a rising edge where valid && ready.
// The master holds req_* stable while req_vld is high and req_rdy is low.
// The responder holds rsp_* stable while rsp_vld is high and rsp_rdy is low.
interface dmem_if #(
  parameter int N_BITS = 32
);
  logic              req_vld;
  logic              req_rdy;
  logic              req_mtype;
  logic [1:0]        req_len;
  logic              req_unsigned;
  logic [N_BITS-1:0] req_addr;
  logic [N_BITS-1:0] req_wdata;
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [N_BITS-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_vld, req_mtype, req_len, req_unsigned, req_addr, req_wdata, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_data, rsp_err
  );

  modport slave (
    input  req_vld, req_mtype, req_len, req_unsigned, req_addr, req_wdata, rsp_rdy,
    output req_rdy, rsp_vld, rsp_data, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised SRAM model serving one byte/half/word
// load or store at a time, with a programmable access latency.
module dmem_responder #(
  parameter int N_BITS      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_if.slave      bus,
  output logic [1:0] state_dbg
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [N_BITS:0] ADDR_LIMIT = (N_BITS+1)'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              mtype_q, mtype_d;
  logic [1:0]        len_q, len_d;
  logic              uns_q, uns_d;
  logic [N_BITS-1:0] addr_q, addr_d;
  logic [N_BITS-1:0] wdata_q, wdata_d;
  logic [N_BITS-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic [N_BITS-1:0] mem [DEPTH_WORDS];

  // Access operands: live bus fields when the access happens on the accept
  // edge (LATENCY == 1), otherwise the fields captured at accept.
  logic              acc_mtype, acc_uns, acc_err, do_access;
  logic [1:0]        acc_len, lane;
  logic [N_BITS-1:0] acc_addr, acc_wdata, rd_word, wr_word, load_val, acc_rdata;
  logic [AW-1:0]     widx;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  // Operand selection, error decode, load extraction and store merge.
  always_comb begin
    if (state_q == IDLE) begin
      acc_mtype = bus.req_mtype;
      acc_len   = bus.req_len;
      acc_uns   = bus.req_unsigned;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end else begin
      acc_mtype = mtype_q;
      acc_len   = len_q;
      acc_uns   = uns_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
    widx     = acc_addr[AW+1:2];
    lane     = acc_addr[1:0];
    rd_word  = mem[widx];
    acc_err  = (acc_len == 2'd3) ||
               (acc_len == 2'd2 && acc_addr[0]) ||
               (acc_len == 2'd0 && lane != 2'd0) ||
               ({1'b0, acc_addr} >= ADDR_LIMIT);
    byte_sel = rd_word[{lane, 3'b000} +: 8];
    half_sel = rd_word[{lane[1], 4'b0000} +: 16];
    case (acc_len)
      2'd1:    load_val = {{(N_BITS-8){~acc_uns & byte_sel[7]}}, byte_sel};
      2'd2:    load_val = {{(N_BITS-16){~acc_uns & half_sel[15]}}, half_sel};
      default: load_val = rd_word;
    endcase
    wr_word = rd_word;
    case (acc_len)
      2'd1:    wr_word[{lane, 3'b000} +: 8] = acc_wdata[7:0];
      2'd2:    wr_word[{lane[1], 4'b0000} +: 16] = acc_wdata[15:0];
      2'd0:    wr_word = acc_wdata;
      default: wr_word = rd_word;
    endcase
    acc_rdata = (acc_err || acc_mtype) ? '0 : load_val;
    do_access = ((state_q == IDLE) && bus.req_vld && (LATENCY == 1)) ||
                ((state_q == WAIT) && (cnt_q == 4'd0));
  end

  // Next-state logic: capture on accept, count down latency, hold response.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mtype_d    = mtype_q;
    len_d      = len_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_vld) begin
          mtype_d = bus.req_mtype;
          len_d   = bus.req_len;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (LATENCY == 1) begin
            state_d    = RESP;
            rsp_data_d = acc_rdata;
            rsp_err_d  = acc_err;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d    = RESP;
          rsp_data_d = acc_rdata;
          rsp_err_d  = acc_err;
        end
      end
      RESP: begin
        if (bus.rsp_rdy) begin
          state_d    = IDLE;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      mtype_q    <= 1'b0;
      len_q      <= 2'd0;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mtype_q    <= mtype_d;
      len_q      <= len_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Array write: only error-free stores, merged with the unaddressed lanes.
  always_ff @(posedge clk) begin
    if (do_access && acc_mtype && !acc_err) begin
      mem[widx] <= wr_word;
    end
  end

  assign bus.req_rdy  = (state_q == IDLE);
  assign bus.rsp_vld  = (state_q == RESP);
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 4, 3) share one set of
// stimulus variables, steered by sel; a byte-level memory model predicts data.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  sel = 2'd0;
  logic        req_vld = 1'b0, req_mtype = 1'b0, req_unsigned = 1'b0, rsp_rdy = 1'b0;
  logic [1:0]  req_len = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        o_rdy, o_vld, o_err;
  logic [31:0] o_data;
  logic [1:0]  dbg0, dbg1, dbg2;

  int checks = 0;
  int passed = 0;
  int lat_of [3] = '{1, 4, 3};
  logic [7:0]  mem_b [3][4096];
  logic [32:0] exp_q [$];

  dmem_if #(.N_BITS(32)) if0 ();
  dmem_if #(.N_BITS(32)) if1 ();
  dmem_if #(.N_BITS(32)) if2 ();

  assign if0.req_vld = req_vld & (sel == 2'd0);
  assign if1.req_vld = req_vld & (sel == 2'd1);
  assign if2.req_vld = req_vld & (sel == 2'd2);
  assign if0.rsp_rdy = rsp_rdy & (sel == 2'd0);
  assign if1.rsp_rdy = rsp_rdy & (sel == 2'd1);
  assign if2.rsp_rdy = rsp_rdy & (sel == 2'd2);
  assign if0.req_mtype = req_mtype;  assign if1.req_mtype = req_mtype;  assign if2.req_mtype = req_mtype;
  assign if0.req_len = req_len;      assign if1.req_len = req_len;      assign if2.req_len = req_len;
  assign if0.req_unsigned = req_unsigned;
  assign if1.req_unsigned = req_unsigned;
  assign if2.req_unsigned = req_unsigned;
  assign if0.req_addr = req_addr;    assign if1.req_addr = req_addr;    assign if2.req_addr = req_addr;
  assign if0.req_wdata = req_wdata;  assign if1.req_wdata = req_wdata;  assign if2.req_wdata = req_wdata;

  always_comb begin
    case (sel)
      2'd1:    begin o_rdy = if1.req_rdy; o_vld = if1.rsp_vld; o_data = if1.rsp_data; o_err = if1.rsp_err; end
      2'd2:    begin o_rdy = if2.req_rdy; o_vld = if2.rsp_vld; o_data = if2.rsp_data; o_err = if2.rsp_err; end
      default: begin o_rdy = if0.req_rdy; o_vld = if0.rsp_vld; o_data = if0.rsp_data; o_err = if0.rsp_err; end
    endcase
  end

  dmem_responder #(.N_BITS(32), .DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave), .state_dbg(dbg0));
  dmem_responder #(.N_BITS(32), .DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave), .state_dbg(dbg1));
  dmem_responder #(.N_BITS(32), .DEPTH_WORDS(1024), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave), .state_dbg(dbg2));

  // Reference model: byte-addressed memory; returns {err, data}.
  function automatic logic [32:0] model_step(int s, bit mt, logic [1:0] ln, bit un,
                                             logic [31:0] ad, logic [31:0] wd);
    int size;
    logic [31:0] v;
    size = (ln == 2'd1) ? 1 : (ln == 2'd2) ? 2 : 4;
    if (ln == 2'd3 || ad >= 32'd4096 || (ad % size) != 0) return {1'b1, 32'h0};
    if (mt) begin
      for (int i = 0; i < size; i++) mem_b[s][ad + i] = wd[8*i +: 8];
      return 33'h0;
    end
    v = 32'h0;
    for (int i = 0; i < size; i++) v = v | (32'(mem_b[s][ad + i]) << (8 * i));
    if (size < 4 && !un && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
    return {1'b0, v};
  endfunction

  // Driver: one full request/response transaction on the selected instance.
  task automatic txn(input bit mt, input logic [1:0] ln, input bit un, input logic [31:0] ad,
                     input logic [31:0] wd, input int stall, input bit hold,
                     output logic [31:0] d, output logic e, output int lat,
                     output bit rdy_low_ok, output bit hold_ok, output bit post_ok, output bit to);
    int n;
    rdy_low_ok = 1; hold_ok = 1; post_ok = 1; to = 0; d = '0; e = 1'b0; lat = 0;
    req_vld = 1'b1; req_mtype = mt; req_len = ln; req_unsigned = un; req_addr = ad; req_wdata = wd;
    n = 0;
    while (!o_rdy && n < 50) begin @(posedge clk); #1; n++; end
    if (!o_rdy) begin to = 1; req_vld = 1'b0; return; end
    @(posedge clk); #1;
    if (!hold) req_vld = 1'b0;
    lat = 1;
    while (!o_vld && lat < 64) begin
      if (o_rdy) rdy_low_ok = 0;
      if (hold) begin
        req_addr = $urandom; req_wdata = $urandom; req_mtype = 1'($urandom); req_len = 2'($urandom);
      end
      @(posedge clk); #1; lat++;
    end
    if (!o_vld) begin to = 1; req_vld = 1'b0; return; end
    d = o_data; e = o_err;
    repeat (stall) begin
      @(posedge clk); #1;
      if (o_rdy || !o_vld || o_data !== d || o_err !== e) hold_ok = 0;
    end
    if (o_rdy) rdy_low_ok = 0;
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    rsp_rdy = 1'b0; req_vld = 1'b0;
    if (o_vld !== 1'b0 || o_rdy !== 1'b1 || o_data !== 32'h0 || o_err !== 1'b0) post_ok = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s); #1;
      checks++; if (o_rdy !== 1'b1) $display("FAIL reset_req_rdy[%0d] got %b want 1", s, o_rdy); else passed++;
      checks++; if (o_vld !== 1'b0) $display("FAIL reset_rsp_vld[%0d] got %b want 0", s, o_vld); else passed++;
      checks++; if (o_data !== 32'h0) $display("FAIL reset_rsp_data[%0d] got %h want 0", s, o_data); else passed++;
      checks++; if (o_err !== 1'b0) $display("FAIL reset_rsp_err[%0d] got %b want 0", s, o_err); else passed++;
    end
    sel = 2'd0;
  endtask

  task automatic test_store_load();
    logic [31:0] d; logic e; int lat; bit r, h, p, to;
    sel = 2'd0;
    void'(model_step(0, 1, 2'd0, 0, 32'h10, 32'hDEADBEEF));
    txn(1, 2'd0, 0, 32'h10, 32'hDEADBEEF, 0, 0, d, e, lat, r, h, p, to);
    checks++; if (to || lat != 1) $display("FAIL store_latency got %0d want 1 (timeout %0d)", lat, to); else passed++;
    checks++; if ({e, d} !== 33'h0) $display("FAIL store_rsp got err %b data %h want 0/0", e, d); else passed++;
    checks++; if (!p) $display("FAIL store_post_handshake got idle-state mismatch want rdy 1 vld 0"); else passed++;
    txn(0, 2'd0, 0, 32'h10, 32'h0, 0, 0, d, e, lat, r, h, p, to);
    checks++; if (to || {e, d} !== {1'b0, 32'hDEADBEEF}) $display("FAIL load_word got err %b data %h want 0/deadbeef", e, d); else passed++;
  endtask

  task automatic test_byte_ext();
    logic [31:0] d; logic e; int lat; bit r, h, p, to;
    sel = 2'd0;
    void'(model_step(0, 1, 2'd1, 0, 32'h13, 32'h80));
    txn(1, 2'd1, 0, 32'h13, 32'h80, 0, 0, d, e, lat, r, h, p, to);
    checks++; if (to || {e, d} !== 33'h0) $display("FAIL store_byte got err %b data %h want 0/0", e, d); else passed++;
    txn(0, 2'd1, 0, 32'h13, 32'h0, 1, 0, d, e, lat, r, h, p, to);
    checks++; if (to || {e, d} !== {1'b0, 32'hFFFFFF80}) $display("FAIL load_byte_signed got %h want ffffff80", d); else passed++;
    txn(0, 2'd1, 1, 32'h13, 32'h0, 0, 0, d, e, lat, r, h, p, to);
    checks++; if (to || {e, d} !== {1'b0, 32'h00000080}) $display("FAIL load_byte_unsigned got %h want 00000080", d); else passed++;
    txn(0, 2'd0, 0, 32'h10, 32'h0, 0, 0, d, e, lat, r, h, p, to);
    checks++; if (to || {e, d} !== {1'b0, 32'h80ADBEEF}) $display("FAIL load_word_after_byte got %h want 80adbeef", d); else passed++;
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int lat; bit r, h, p, to;
    logic [31:0] addrs [4] = '{32'h11, 32'h12, 32'h0, 32'd4096};
    logic [1:0]  lens  [4] = '{2'd2, 2'd0, 2'd3, 2'd0};
    sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      txn(0, lens[i], 0, addrs[i], 32'h0, 0, 0, d, e, lat, r, h, p, to);
      checks++;
      if (to || e !== 1'b1 || d !== 32'h0) $display("FAIL error_load[%0d] got err %b data %h want 1/0", i, e, d);
      else passed++;
    end
    txn(1, 2'd2, 0, 32'h11, 32'hFFFF, 0, 0, d, e, lat, r, h, p, to);
    checks++; if (to || e !== 1'b1 || d !== 32'h0) $display("FAIL error_store_half got err %b data %h want 1/0", e, d); else passed++;
    txn(0, 2'd0, 0, 32'h10, 32'h0, 0, 0, d, e, lat, r, h, p, to);
    checks++; if (to || {e, d} !== {1'b0, 32'h80ADBEEF}) $display("FAIL error_store_no_write got %h want 80adbeef", d); else passed++;
  endtask

  task automatic test_latency_stall();
    logic [31:0] d; logic e; int lat; bit r, h, p, to;
    sel = 2'd1;
    void'(model_step(1, 1, 2'd0, 0, 32'h40, 32'h11223344));
    txn(1, 2'd0, 0, 32'h40, 32'h11223344, 0, 0, d, e, lat, r, h, p, to);
    checks++; if (to || lat != 4) $display("FAIL lat4_store latency got %0d want 4", lat); else passed++;
    txn(0, 2'd0, 0, 32'h40, 32'h0, 3, 0, d, e, lat, r, h, p, to);
    checks++; if (to || lat != 4) $display("FAIL lat4_load latency got %0d want 4", lat); else passed++;
    checks++; if ({e, d} !== {1'b0, 32'h11223344}) $display("FAIL lat4_load_data got %h want 11223344", d); else passed++;
    checks++; if (!h) $display("FAIL stall_hold got unstable response want stable"); else passed++;
    checks++; if (!r) $display("FAIL stall_req_rdy got high during txn want low"); else passed++;
    checks++; if (!p) $display("FAIL stall_post got not idle want rdy 1 vld 0"); else passed++;
  endtask

  task automatic test_hold_inputs();
    logic [31:0] d; logic e; int lat; bit r, h, p, to; int extra;
    sel = 2'd1;
    txn(0, 2'd0, 0, 32'h40, 32'h0, 1, 1, d, e, lat, r, h, p, to);
    checks++; if (to || {e, d} !== {1'b0, 32'h11223344}) $display("FAIL hold_captured got err %b data %h want 0/11223344", e, d); else passed++;
    checks++; if (!r) $display("FAIL hold_no_second_accept got req_rdy high in txn want low"); else passed++;
    extra = 0;
    repeat (3) begin @(posedge clk); #1; if (o_vld || !o_rdy) extra++; end
    checks++; if (extra != 0) $display("FAIL hold_after_idle got %0d busy cycles want 0", extra); else passed++;
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] d; logic e; int lat; bit r, h, p, to; int seen;
    sel = 2'd2;
    void'(model_step(2, 1, 2'd0, 0, 32'h20, 32'hA5A5A5A5));
    txn(1, 2'd0, 0, 32'h20, 32'hA5A5A5A5, 0, 0, d, e, lat, r, h, p, to);
    checks++; if (to || lat != 3) $display("FAIL lat3_store latency got %0d want 3", lat); else passed++;
    req_vld = 1'b1; req_mtype = 1'b1; req_len = 2'd0; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_vld = 1'b0;
    checks++; if (o_rdy !== 1'b0) $display("FAIL wait_entered got req_rdy %b want 0", o_rdy); else passed++;
    rst_n = 1'b0; #2; rst_n = 1'b1; #1;
    checks++; if (o_rdy !== 1'b1 || o_vld !== 1'b0) $display("FAIL reset_in_wait got rdy %b vld %b want 1/0", o_rdy, o_vld); else passed++;
    seen = 0;
    repeat (4) begin @(posedge clk); #1; if (o_vld) seen++; end
    checks++; if (seen != 0) $display("FAIL reset_lost_rsp got %0d vld cycles want 0", seen); else passed++;
    txn(0, 2'd0, 0, 32'h20, 32'h0, 0, 0, d, e, lat, r, h, p, to);
    checks++; if (to || {e, d} !== {1'b0, 32'hA5A5A5A5}) $display("FAIL store_dropped got %h want a5a5a5a5", d); else passed++;
  endtask

  task automatic test_random(input int s, input int n_ops);
    logic [31:0] d, ad, wd; logic e; int lat; bit r, h, p, to, mt, un; logic [1:0] ln;
    logic [32:0] exp;
    sel = 2'(s);
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      void'(model_step(s, 1, 2'd0, 0, 32'(4 * w), wd));
      txn(1, 2'd0, 0, 32'(4 * w), wd, 0, 0, d, e, lat, r, h, p, to);
    end
    for (int i = 0; i < n_ops; i++) begin
      mt = 1'($urandom_range(0, 1));
      un = 1'($urandom_range(0, 1));
      ln = 2'($urandom_range(0, 3));
      ad = ($urandom_range(0, 9) == 0) ? 32'(4096 + $urandom_range(0, 63)) : 32'($urandom_range(0, 63));
      wd = $urandom;
      exp_q.push_back(model_step(s, mt, ln, un, ad, wd));
      txn(mt, ln, un, ad, wd, $urandom_range(0, 2), 0, d, e, lat, r, h, p, to);
      exp = exp_q.pop_front();
      checks++;
      if (to || {e, d} !== exp)
        $display("FAIL rand[%0d.%0d] mt %0d len %0d addr %h got %b/%h want %b/%h", s, i, mt, ln, ad, e, d, exp[32], exp[31:0]);
      else passed++;
      checks++;
      if (lat != lat_of[s]) $display("FAIL rand_lat[%0d.%0d] got %0d want %0d", s, i, lat, lat_of[s]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_ext();
    test_errors();
    test_latency_stall();
    test_hold_inputs();
    test_reset_in_wait();
    test_random(0, 30);
    test_random(1, 20);
    test_random(2, 20);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
